// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback-port arbiter.
package wb_arb_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]     rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_req_t;

    // r0 is never a real destination, so it maps to an empty mask
    function automatic logic [31:0] onehot32(input logic [REG_ADDR_W-1:0] rd);
        onehot32 = (rd == '0) ? 32'd0 : (32'd1 << rd);
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Small synchronous FIFO of writeback requests; exposes every slot and its
// validity so the owner can build a pending-destination mask.
module wb_req_fifo
    import wb_arb_pkg::*;
#(
    parameter type         entry_t = wb_req_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head,
    output entry_t [DEPTH-1:0]       entries,
    output logic   [DEPTH-1:0]       ent_valid,
    output logic   [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem [DEPTH];
    logic   [AW-1:0] wr_ptr;
    logic   [AW-1:0] rd_ptr;
    logic   [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        logic [AW-1:0] off;
        off       = '0;
        ent_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i]   = mem[i];
            off          = AW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < cnt);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback slot (priority)
// and queued MDU results. Optional same-cycle MDU bypass: MDU_BYPASS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_regwrite,
    input  logic [REG_ADDR_W-1:0]   pipe_rd,
    input  logic [DATA_W-1:0]       pipe_data,
    input  logic                    mdu_valid,
    input  logic [REG_ADDR_W-1:0]   mdu_rd,
    input  logic [DATA_W-1:0]       mdu_data,
    output logic                    mdu_ready,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_wa,
    output logic [DATA_W-1:0]       rf_wd,
    output logic                    stall_req,
    output logic [31:0]             busy_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } req_t;

    logic                 pipe_act;
    logic                 room;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    req_t                 push_entry;
    req_t                 head;
    req_t [DEPTH-1:0]     entries;
    logic [DEPTH-1:0]     ent_valid;
    logic [CW-1:0]        count;
    logic [WW-1:0]        wait_q;
    logic [WW-1:0]        wait_d;

    assign pipe_act = pipe_regwrite && (pipe_rd != '0);
    assign room     = (count < CW'(DEPTH));

`ifdef MDU_BYPASS_EN
    // Empty queue and idle slot: the MDU result goes straight to the port
    assign bypass = (count == '0) && !pipe_act && mdu_valid && (mdu_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    assign push       = !rst && mdu_valid && room && (mdu_rd != '0) && !bypass;
    assign pop        = !rst && !pipe_act && (count != '0);
    assign push_entry = '{rd: mdu_rd, data: mdu_data};

    wb_req_fifo #(
        .entry_t (req_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .entries    (entries),
        .ent_valid  (ent_valid),
        .count      (count)
    );

    // Write-port mux: pipeline first, then FIFO head, then bypassed MDU result
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (!rst) begin
            if (pipe_act) begin
                rf_we = 1'b1;
                rf_wa = pipe_rd;
                rf_wd = pipe_data;
            end else if (count != '0) begin
                rf_we = 1'b1;
                rf_wa = head.rd;
                rf_wd = head.data;
            end else if (bypass) begin
                rf_we = 1'b1;
                rf_wa = mdu_rd;
                rf_wd = mdu_data;
            end
        end
    end

    // Starvation counter: grows while the head is blocked, cleared by any pop
    always_comb begin
        wait_d = wait_q;
        if (pop) begin
            wait_d = '0;
        end else if ((count != '0) && pipe_act && (wait_q != WW'(STARVE_LIMIT))) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end

    assign stall_req = !rst && (wait_q == WW'(STARVE_LIMIT));
    assign mdu_ready = !rst && room;

    always_comb begin
        busy_mask = '0;
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_valid[i]) busy_mask = busy_mask | onehot32(entries[i].rd);
            end
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes go to a scoreboard queue,
// a negedge monitor pops them whenever the register-file port fires.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_regwrite;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [31:0] busy_mask;
    logic [1:0]  fifo_count;

    wb_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_regwrite (pipe_regwrite),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .mdu_valid     (mdu_valid),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .rf_we         (rf_we),
        .rf_wa         (rf_wa),
        .rf_wd         (rf_wd),
        .stall_req     (stall_req),
        .busy_mask     (busy_mask),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_regwrite = pw;
        pipe_rd       = prd;
        pipe_data     = pd;
        mdu_valid     = mv;
        mdu_rd        = mrd;
        mdu_data      = md;
    endtask

    task automatic exp_wr(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back('{wa, wd});
    endtask

    // Monitor: every register-file write must match the next expected write
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got wa=%0d wd=0x%0h, want no write", rf_wa, rf_wd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_write", {27'd0, rf_wa, rf_wd}, {27'd0, mon_e.wa, mon_e.wd});
            end
        end else if (rf_we !== 1'b0) begin
            n_checks++;
            $display("FAIL rf_we_unknown: got %b, want 0 or 1", rf_we);
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);

        // Reset held two edges with an MDU result offered
        cyc(); cyc(); settle();
        chk("reset_mdu_ready", 64'(mdu_ready), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_busy", 64'(busy_mask), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);

        cyc(); rst = 1'b0; drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); settle();
        chk("post_reset_ready", 64'(mdu_ready), 64'd1);

        // Idle drain of a single MDU result
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef MDU_BYPASS_EN
        exp_wr(5'd5, 32'hDEADBEEF);
        settle();
        chk("drain_bypass_we", 64'(rf_we), 64'd1);
`else
        settle();
        chk("drain_push_cycle_we", 64'(rf_we), 64'd0);
`endif
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef MDU_BYPASS_EN
        settle();
        chk("drain_bypass_busy", 64'(busy_mask), 64'd0);
`else
        exp_wr(5'd5, 32'hDEADBEEF);
        settle();
        chk("drain_wa", 64'(rf_wa), 64'd5);
        chk("drain_busy", 64'(busy_mask), 64'h20);
        chk("drain_count", 64'(fifo_count), 64'd1);
`endif
        cyc(); settle();
        chk("drain_busy_clear", 64'(busy_mask), 64'd0);
        chk("drain_count_clear", 64'(fifo_count), 64'd0);

        // Starvation: pipeline writes r3 every cycle while r7 and r8 queue
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77); exp_wr(5'd3, 32'h11);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd8, 32'h88); exp_wr(5'd3, 32'h11);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd10, 32'hAA); exp_wr(5'd3, 32'h11); settle();
        chk("starve_count", 64'(fifo_count), 64'd2);
        chk("starve_ready", 64'(mdu_ready), 64'd0);
        chk("starve_busy", 64'(busy_mask), 64'h180);
        chk("starve_wa", 64'(rf_wa), 64'd3);
        chk("starve_stall_early", 64'(stall_req), 64'd0);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0); exp_wr(5'd3, 32'h11); settle();
        chk("full_no_accept_count", 64'(fifo_count), 64'd2);
        chk("full_no_accept_busy", 64'(busy_mask), 64'h180);
        cyc(); exp_wr(5'd3, 32'h11); settle();
        chk("stall_after_3", 64'(stall_req), 64'd0);
        cyc(); exp_wr(5'd3, 32'h11); settle();
        chk("stall_after_4", 64'(stall_req), 64'd1);
        cyc(); exp_wr(5'd3, 32'h11); settle();
        chk("stall_holds", 64'(stall_req), 64'd1);
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); exp_wr(5'd7, 32'h77); settle();
        chk("release_wa", 64'(rf_wa), 64'd7);
        chk("release_stall_still", 64'(stall_req), 64'd1);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0); exp_wr(5'd3, 32'h11); settle();
        chk("stall_fall", 64'(stall_req), 64'd0);
        chk("one_left_count", 64'(fifo_count), 64'd1);
        chk("one_left_busy", 64'(busy_mask), 64'h100);
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); exp_wr(5'd8, 32'h88); settle();
        chk("second_drain_wa", 64'(rf_wa), 64'd8);
        cyc(); settle();
        chk("starve_end_count", 64'(fifo_count), 64'd0);
        chk("starve_end_busy", 64'(busy_mask), 64'd0);

        // r0 handling: pipeline write to r0 is an idle slot; MDU r0 is dropped
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd12, 32'hC); exp_wr(5'd3, 32'h11);
        cyc(); drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0); exp_wr(5'd12, 32'hC); settle();
        chk("r0_slot_drain_wa", 64'(rf_wa), 64'd12);
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF); settle();
        chk("r0_mdu_ready", 64'(mdu_ready), 64'd1);
        chk("r0_mdu_we", 64'(rf_we), 64'd0);
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); settle();
        chk("r0_mdu_count", 64'(fifo_count), 64'd0);

        // Reset mid-operation with two entries queued and stall raised
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd20, 32'h14); exp_wr(5'd3, 32'h11);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd21, 32'h15); exp_wr(5'd3, 32'h11);
        cyc(); drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0); exp_wr(5'd3, 32'h11);
        cyc(); exp_wr(5'd3, 32'h11);
        cyc(); exp_wr(5'd3, 32'h11);
        cyc(); exp_wr(5'd3, 32'h11); settle();
        chk("pre_rst_stall", 64'(stall_req), 64'd1);
        chk("pre_rst_busy", 64'(busy_mask), 64'h300000);
        cyc(); rst = 1'b1; drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd22, 32'h16); settle();
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_stall", 64'(stall_req), 64'd0);
        chk("mid_rst_ready", 64'(mdu_ready), 64'd0);
        cyc(); rst = 1'b0; drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); settle();
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_busy", 64'(busy_mask), 64'd0);
        chk("post_rst_stall", 64'(stall_req), 64'd0);
        cyc(); settle();
        chk("no_stale_write", 64'(rf_we), 64'd0);

        // MDU write latency, then a push and pop in the same cycle
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h5A);
`ifdef MDU_BYPASS_EN
        exp_wr(5'd9, 32'h5A); settle();
        chk("bypass_wa", 64'(rf_wa), 64'd9);
        chk("bypass_we", 64'(rf_we), 64'd1);
`else
        settle();
        chk("latency_we", 64'(rf_we), 64'd0);
`endif
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA);
`ifdef MDU_BYPASS_EN
        exp_wr(5'd10, 32'hA); settle();
        chk("bypass_count", 64'(fifo_count), 64'd0);
`else
        exp_wr(5'd9, 32'h5A); settle();
        chk("latency_wa", 64'(rf_wa), 64'd9);
        chk("latency_count", 64'(fifo_count), 64'd1);
`endif
        cyc(); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef MDU_BYPASS_EN
        settle();
        chk("bypass_busy", 64'(busy_mask), 64'd0);
`else
        exp_wr(5'd10, 32'hA); settle();
        chk("pushpop_count", 64'(fifo_count), 64'd1);
        chk("pushpop_wa", 64'(rf_wa), 64'd10);
`endif
        cyc(); settle();
        chk("final_count", 64'(fifo_count), 64'd0);
        cyc(); settle();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
